knn_topk_select: RTL and testbench
==================================

# knn_topk_select

Streaming top-K selector for the KNN distance path. Accepts one (distance, class type) pair per cycle from the distance stage. Keeps the K smallest distances seen since the last `start` in a sorted register array, using an insertion shift-register. After the last sample it presents the K nearest neighbours, ascending, to the downstream voting/classification stage.

## Interface
- `W`, default 16: distance width, unsigned.
- `TYPE_W`, default 4: class-type label width.
- `K`, default 8: number of neighbours kept, K ≥ 2.
- `CNT_W`, default $clog2(K+1): width of `out_count`.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; clears the list and begins a new query.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  block accepts samples.
- `in_dist`  in  W  candidate distance.
- `in_type`  in  TYPE_W  candidate class type.
- `in_last`  in  1  qualifies the final sample of a query.
- `out_valid`  out  1  result stable and complete.
- `out_dist`  out  K*W  sorted distances; slot 0 (smallest) in bits [W-1:0].
- `out_type`  out  K*TYPE_W  types matching `out_dist`, same slot order.
- `out_count`  out  CNT_W  number of filled slots, saturates at K.

## Operation
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: `in_ready`=0, `out_valid`=0. On `start`: go to COLLECT.
  - COLLECT: `in_ready`=1. On accept with `in_last`=1: go to DONE.
  - DONE: `out_valid`=1. Registers are frozen. On `start`: go to COLLECT.
- Accept condition: `in_valid && in_ready`. Samples offered while `in_ready`=0 are ignored; they are not back-pressured into a later cycle.
- `start` clears the list in every state:
  - all slot valid flags = 0, all distances = all-ones, all types = 0, `out_count` = 0.
  - `start` has priority over a same-cycle `in_valid`; that sample is dropped.
- Slot array: per slot i there is `dist[i]`, `type[i]` and `vld[i]`. Slots are sorted ascending, and filled slots are contiguous from slot 0.
- Per-slot compare for each accepted sample: `beat[i] = !vld[i] || (in_dist < dist[i])`. The compare is strict and unsigned.
- Insertion, evaluated in parallel for all slots:
  - If `beat[i]` and `beat[i-1]` (i>0): slot i takes slot i-1's contents (shift).
  - If `beat[i]` and not `beat[i-1]`, or i=0 with `beat[0]`: slot i takes the new sample and `vld[i]`=1.
  - Otherwise slot i holds.
  - Slot K-1's previous contents are discarded on a shift.
- Ties: an equal distance does not beat an existing slot. The earlier arrival stays in the lower slot, so the sort is stable.
- A sample that beats no slot is dropped, with no state change other than the FSM.
- `out_count` increments on each accepted sample while below K, then holds at K.
- Empty slots read as distance all-ones, type 0, and are excluded by `out_count`. A real all-ones sample still fills an empty slot because it beats `!vld`.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `out_valid`=0, `out_count`=0, every `out_dist` slot all-ones, every `out_type` slot 0.
- `rst` mid-query: the next cycle is IDLE with all reset values. The in-flight sample is lost.
- Sample accepted at edge n is visible in `out_dist`/`out_type`/`out_count` after edge n.
- Final sample accepted at edge n: `out_valid`=1 from edge n (combinational from state DONE, entered at edge n). It holds until the next `start` or `rst`.
- `start` at edge n: `in_ready`=1 and the list is clear after edge n. The earliest accepted sample is at edge n+1.
- Throughput is one sample per cycle with no bubbles. Insertion is a single cycle: one compare and one mux level per slot.
- `in_last` with `in_valid`=0 has no effect.
- A zero-sample query cannot end; only `start` or `rst` leaves COLLECT.

## Test plan
Use K=4, W=8, TYPE_W=2 throughout.
- Basic sort: `start`, then stream (dist,type) (50,1),(20,2),(70,3),(10,0),(30,1) with last on (30,1). Required: `out_valid`=1 the cycle after; dist slots 0..3 = 10,20,30,50; types 0,2,1,1; `out_count`=4; 70 dropped.
- Ties and stability: stream (40,1),(40,2),(40,3). Required: slots 0..2 = 40/type1, 40/type2, 40/type3; slot 3 = 255/0; `out_count`=3.
- Boundary values: stream (255,3) then (0,1), last. Required: slots = 0/1, 255/3, then 255/0, 255/0; `out_count`=2.
- Back-to-back queries: `start` on the same cycle as `in_valid`(5,1), then (9,2) last. Required: 5 dropped; result slot 0 = 9/2, `out_count`=1. A second `start` in DONE drops `out_valid` next cycle and clears all slots.
- Reset mid-query: after 3 accepted samples, assert `rst` for one cycle together with `in_valid`. Required: IDLE next cycle; `in_ready`=0; `out_count`=0; all slots 255/0; later `in_valid` ignored until `start`.
- Random: 1000 queries of 1–20 random samples checked against a reference model of the stable ascending first K. `in_valid` is toggled randomly, including cycles with `in_ready`=0.

Source files
------------

// File: rtl/knn_topk_select.sv
`default_nettype none
// ============================================================================
// Module   : knn_topk_select
// Brief    : Streaming top-K smallest-distance selector (insertion shift array)
// Revision : 1.0 - initial release
// ============================================================================
module knn_topk_select #(
    parameter int W      = 16,
    parameter int TYPE_W = 4,
    parameter int K      = 8,
    parameter int CNT_W  = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_dist,
    input  logic [TYPE_W-1:0]     in_type,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [K*W-1:0]        out_dist,
    output logic [K*TYPE_W-1:0]   out_type,
    output logic [CNT_W-1:0]      out_count
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [W-1:0]      dist_q [K];
    logic [W-1:0]      dist_d [K];
    logic [W-1:0]      src_dist [K];
    logic [TYPE_W-1:0] type_q [K];
    logic [TYPE_W-1:0] type_d [K];
    logic [TYPE_W-1:0] src_type [K];
    logic [K-1:0]      vld_q, vld_d, src_vld;
    logic [K-1:0]      beat, beat_prev;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              accept;

    assign in_ready  = (state_q == c_COLLECT);
    assign out_valid = (state_q == c_DONE);
    assign out_count = count_q;
    // start wins over a same-cycle sample
    assign accept    = in_valid && in_ready && !start;

    generate
        for (genvar i = 0; i < K; i++) begin : g_slot
            assign beat[i] = !vld_q[i] || (in_dist < dist_q[i]);
            if (i == 0) begin : g_head
                assign beat_prev[i] = 1'b0;
                assign src_dist[i]  = in_dist;
                assign src_type[i]  = in_type;
                assign src_vld[i]   = 1'b1;
            end else begin : g_body
                assign beat_prev[i] = !vld_q[i-1] || (in_dist < dist_q[i-1]);
                assign src_dist[i]  = dist_q[i-1];
                assign src_type[i]  = type_q[i-1];
                assign src_vld[i]   = vld_q[i-1];
            end
            assign out_dist[i*W +: W]           = dist_q[i];
            assign out_type[i*TYPE_W +: TYPE_W] = type_q[i];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        dist_d  = dist_q;
        type_d  = type_q;
        vld_d   = vld_q;
        count_d = count_q;
        if (start) begin
            state_d = c_COLLECT;
            vld_d   = '0;
            count_d = '0;
            for (int i = 0; i < K; i++) begin
                dist_d[i] = '1;
                type_d[i] = '0;
            end
        end else if (accept) begin
            if (in_last) begin
                state_d = c_DONE;
            end
            if (count_q != CNT_W'(K)) begin
                count_d = count_q + 1'b1;
            end
            // Slots beaten along with their lower neighbour shift up; the
            // lowest beaten slot takes the new sample.
            for (int i = 0; i < K; i++) begin
                if (beat[i] && beat_prev[i]) begin
                    dist_d[i] = src_dist[i];
                    type_d[i] = src_type[i];
                    vld_d[i]  = src_vld[i];
                end else if (beat[i]) begin
                    dist_d[i] = in_dist;
                    type_d[i] = in_type;
                    vld_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '1;
                type_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            count_q <= count_d;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= dist_d[i];
                type_q[i] <= type_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_topk_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_knn_topk_select
// Brief    : Self-checking bench for knn_topk_select against a stable-sort model
// Revision : 1.0 - initial release
// ============================================================================
module tb_knn_topk_select;

    localparam int W      = 8;
    localparam int TYPE_W = 2;
    localparam int K      = 4;
    localparam int CNT_W  = $clog2(K + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_dist;
    logic [TYPE_W-1:0]   in_type;
    logic                in_last;
    logic                out_valid;
    logic [K*W-1:0]      out_dist;
    logic [K*TYPE_W-1:0] out_type;
    logic [CNT_W-1:0]    out_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: 0 idle, 1 collecting, 2 done; all accepted samples of the query
    int          m_state = 0;
    int unsigned m_dist[$];
    int unsigned m_type[$];

    knn_topk_select #(.W(W), .TYPE_W(TYPE_W), .K(K), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dist   (in_dist),
        .in_type   (in_type),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_dist  (out_dist),
        .out_type  (out_type),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected slots: the K smallest accepted samples, ties kept in arrival order
    task automatic compare_all();
        bit          used [64];
        int          best;
        int unsigned e_dist, e_type;
        logic [W-1:0]      o_d;
        logic [TYPE_W-1:0] o_t;
        int          n;
        n = m_dist.size();
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        check("in_ready", {31'd0, in_ready}, (m_state == 1) ? 32'd1 : 32'd0);
        check("out_valid", {31'd0, out_valid}, (m_state == 2) ? 32'd1 : 32'd0);
        check("out_count", 32'(out_count), (n < K) ? n : K);
        for (int j = 0; j < K; j++) begin
            best = -1;
            for (int i = 0; i < n; i++) begin
                if (!used[i] && (best < 0 || m_dist[i] < m_dist[best])) best = i;
            end
            if (best >= 0) begin
                used[best] = 1'b1;
                e_dist = m_dist[best];
                e_type = m_type[best];
            end else begin
                e_dist = 255;
                e_type = 0;
            end
            o_d = out_dist[j*W +: W];
            o_t = out_type[j*TYPE_W +: TYPE_W];
            check($sformatf("dist%0d", j), 32'(o_d), e_dist);
            check($sformatf("type%0d", j), 32'(o_t), e_type);
        end
    endtask

    task automatic cyc(input bit s, input bit v, input int d, input int t,
                       input bit l, input bit r);
        rst      = r;
        start    = s;
        in_valid = v;
        in_dist  = d[W-1:0];
        in_type  = t[TYPE_W-1:0];
        in_last  = l;
        if (r) begin
            m_state = 0;
            m_dist.delete();
            m_type.delete();
        end else if (s) begin
            m_state = 1;
            m_dist.delete();
            m_type.delete();
        end else if (v && m_state == 1) begin
            m_dist.push_back(d);
            m_type.push_back(t);
            if (l) m_state = 2;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send(input int d, input int t, input bit l);
        cyc(1'b0, 1'b1, d, t, l, 1'b0);
    endtask

    task automatic idle_cycle();
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, sent, d;
        bit v;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_dist = '0; in_type = '0; in_last = 1'b0;

        // Reset state
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 33, 1, 1'b1, 1'b1);
        idle_cycle();
        send(12, 1, 1'b1);

        // Basic sort
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        send(50, 1, 1'b0);
        send(20, 2, 1'b0);
        send(70, 3, 1'b0);
        send(10, 0, 1'b0);
        send(30, 1, 1'b1);
        check("basic_valid", {31'd0, out_valid}, 32'd1);
        check("basic_d0", 32'(out_dist[7:0]), 32'd10);
        check("basic_d3", 32'(out_dist[31:24]), 32'd50);
        check("basic_types", 32'(out_type), 32'b01_01_10_00);
        check("basic_count", 32'(out_count), 32'd4);
        idle_cycle();
        send(1, 3, 1'b0);

        // Ties and stability
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        send(40, 1, 1'b0);
        send(40, 2, 1'b0);
        send(40, 3, 1'b1);
        check("tie_types", 32'(out_type), 32'b00_11_10_01);
        check("tie_slot3", 32'(out_dist[31:24]), 32'd255);

        // Boundary values
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        send(255, 3, 1'b0);
        send(0, 1, 1'b1);
        check("bound_d0", 32'(out_dist[7:0]), 32'd0);
        check("bound_d1", 32'(out_dist[15:8]), 32'd255);
        check("bound_count", 32'(out_count), 32'd2);

        // Back-to-back: sample on the start cycle is dropped
        cyc(1'b1, 1'b1, 5, 1, 1'b0, 1'b0);
        send(9, 2, 1'b1);
        check("b2b_d0", 32'(out_dist[7:0]), 32'd9);
        check("b2b_count", 32'(out_count), 32'd1);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("b2b_restart_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-query
        send(7, 1, 1'b0);
        send(3, 2, 1'b0);
        send(8, 3, 1'b0);
        cyc(1'b0, 1'b1, 1, 1, 1'b0, 1'b1);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        send(2, 2, 1'b0);
        send(4, 1, 1'b1);

        // Zero-sample query stays in COLLECT; in_last without in_valid ignored
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6, 1, 1'b1, 1'b0);
        idle_cycle();

        // Random queries
        for (int q = 0; q < 1000; q++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                cyc(1'b0, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 3),
                    1'($urandom), 1'b0);
            end
            cyc(1'b1, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 3),
                1'($urandom), 1'b0);
            n    = $urandom_range(1, 20);
            sent = 0;
            while (sent < n) begin
                v = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 3))
                    0:       d = $urandom_range(0, 7);
                    1:       d = 255;
                    default: d = $urandom_range(0, 255);
                endcase
                cyc(1'b0, v, d, $urandom_range(0, 3), (sent == n - 1), 1'b0);
                if (v) sent++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
